// File: rtl/uart_mem_responder_pkg.sv
// Shared constants and state encoding for the UART memory responder and its byte sender.
package uart_mem_responder_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_GET_ADDR  = 4'd1;
    localparam logic [3:0] ST_GET_DATA  = 4'd2;
    localparam logic [3:0] ST_MEM_WR    = 4'd3;
    localparam logic [3:0] ST_MEM_RD    = 4'd4;
    localparam logic [3:0] ST_MEM_CAP   = 4'd5;
    localparam logic [3:0] ST_SEND      = 4'd6;
    localparam logic [3:0] ST_WAIT_ACT  = 4'd7;
    localparam logic [3:0] ST_WAIT_DONE = 4'd8;

    typedef enum logic [3:0] {
        StIdle     = ST_IDLE,
        StGetAddr  = ST_GET_ADDR,
        StGetData  = ST_GET_DATA,
        StMemWr    = ST_MEM_WR,
        StMemRd    = ST_MEM_RD,
        StMemCap   = ST_MEM_CAP,
        StSend     = ST_SEND,
        StWaitAct  = ST_WAIT_ACT,
        StWaitDone = ST_WAIT_DONE
    } state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/uart_mem_responder_if.sv
// UART handshake and word-wide memory port bundle; master is the responder side.
interface uart_mem_responder_if;

    logic        RX_STATUS;
    logic [7:0]  RX_DATA;
    logic        TX_STATUS;
    logic        TX_EN;
    logic [7:0]  TX_DATA;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  RX_STATUS, RX_DATA, TX_STATUS, mem_rdata,
        output TX_EN, TX_DATA, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output RX_STATUS, RX_DATA, TX_STATUS, mem_rdata,
        input  TX_EN, TX_DATA, mem_rd, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/uart_byte_sender.sv
// Sends one byte per start through the UART transmitter busy handshake; done pulses when
// the transmitter has gone idle again, and a start in that same cycle chains the next byte.
module uart_byte_sender
    import uart_mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       tx_status_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       done_o
);

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tx_en_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StSend: begin
                if (!tx_status_i) begin
                    tx_en_o = 1'b1;
                    state_d = StWaitAct;
                end
            end
            // Transmitter raises TX_STATUS one cycle after TX_EN.
            StWaitAct: state_d = StWaitDone;
            StWaitDone: begin
                if (!tx_status_i) begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start_i && (state_q == StIdle || done_o)) begin
            state_d = StSend;
            data_d  = byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign tx_data_o = data_q;

endmodule

// File: rtl/uart_mem_responder.sv
// Host-side debug responder: decodes UART W/R commands into word memory accesses and replies.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_mem_responder
    import uart_mem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_mem_responder_if.master bus,
    output logic                 hold,
    output logic                 busy
);

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  rx_cnt_q, rx_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_q, rsp_d;
    logic [2:0]  rsp_cnt_q, rsp_cnt_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;

    logic        snd_start;
    logic [7:0]  snd_byte;
    logic        snd_done;

`ifdef CMD_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        rx_cnt_d  = rx_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsp_d     = rsp_q;
        rsp_cnt_d = rsp_cnt_q;
        snd_start = 1'b0;
        snd_byte  = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (bus.RX_STATUS) begin
                    is_wr_d  = (bus.RX_DATA == CMD_WR);
                    rx_cnt_d = 2'd0;
                    if (bus.RX_DATA == CMD_WR || bus.RX_DATA == CMD_RD) begin
                        state_d = StGetAddr;
                    end else begin
                        rsp_cnt_d = 3'd1;
                        snd_start = 1'b1;
                        snd_byte  = RSP_ERR;
                        state_d   = StSend;
                    end
                end
            end
            StGetAddr: begin
                if (bus.RX_STATUS) begin
                    addr_d   = {addr_q[23:0], bus.RX_DATA};
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    if (rx_cnt_q == 2'd3) begin
                        state_d = is_wr_q ? StGetData : StMemRd;
                    end
                end
            end
            StGetData: begin
                if (bus.RX_STATUS) begin
                    wdata_d  = {wdata_q[23:0], bus.RX_DATA};
                    rx_cnt_d = rx_cnt_q + 2'd1;
                    if (rx_cnt_q == 2'd3) begin
                        state_d = StMemWr;
                    end
                end
            end
            StMemWr: begin
                rsp_cnt_d = 3'd1;
                snd_start = 1'b1;
                snd_byte  = RSP_OK;
                state_d   = StSend;
            end
            StMemRd: state_d = StMemCap;
            StMemCap: begin
                rsp_d     = bus.mem_rdata;
                rsp_cnt_d = 3'd4;
                snd_start = 1'b1;
                snd_byte  = bus.mem_rdata[31:24];
                state_d   = StSend;
            end
            // The sender owns the per-byte handshake; here we only sequence the bytes.
            StSend: begin
                if (snd_done) begin
                    rsp_cnt_d = rsp_cnt_q - 3'd1;
                    if (rsp_cnt_q == 3'd1) begin
                        state_d = StIdle;
                    end else begin
                        rsp_d     = {rsp_q[23:0], 8'h00};
                        snd_start = 1'b1;
                        snd_byte  = rsp_q[23:16];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef CMD_TIMEOUT_EN
        to_cnt_d = 32'd0;
        if ((state_q == StGetAddr || state_q == StGetData) && !bus.RX_STATUS) begin
            to_cnt_d = to_cnt_q + 32'd1;
            if (to_cnt_d >= TIMEOUT_CYCLES) begin
                state_d  = StIdle;
                to_cnt_d = 32'd0;
            end
        end
`endif

        mem_rd_d = (state_d == StMemRd) || (state_d == StMemCap);
        mem_wr_d = (state_d == StMemWr);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            rx_cnt_q  <= 2'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_q     <= 32'h0;
            rsp_cnt_q <= 3'd0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            rx_cnt_q  <= rx_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rsp_q     <= rsp_d;
            rsp_cnt_q <= rsp_cnt_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= 32'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    uart_byte_sender u_sender (
        .clk         (clk),
        .reset       (reset),
        .start_i     (snd_start),
        .byte_i      (snd_byte),
        .tx_status_i (bus.TX_STATUS),
        .tx_en_o     (bus.TX_EN),
        .tx_data_o   (bus.TX_DATA),
        .done_o      (snd_done)
    );

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = word_addr(addr_q);
    assign bus.mem_wdata = wdata_q;
    assign hold          = busy_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// Scoreboard bench for uart_mem_responder: models the UART transmitter and data memory,
// queues expected TX bytes and memory writes, and checks them as the DUT produces them.
module tb_uart_mem_responder;

    typedef logic [7:0] pkt_t [9];

    logic clk = 1'b0;
    logic reset;
    logic hold;
    logic busy;

    uart_mem_responder_if bus ();

    uart_mem_responder #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .hold  (hold),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_tx [$];
    logic [63:0] exp_wr [$];
    int          tx_count   = 0;
    int          wr_cycles  = 0;
    int          rd_cycles  = 0;
    logic [7:0]  last_tx    = 8'h00;

    logic        preload_en = 1'b0;
    logic [7:0]  preload_idx = 8'h00;
    logic [31:0] preload_data = 32'h0;
    logic [31:0] mem [0:255];
    int unsigned tx_busy_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter: busy starts one cycle after TX_EN and lasts six cycles.
    always @(posedge clk) begin
        if (reset) tx_busy_cnt <= 0;
        else if (bus.TX_EN) tx_busy_cnt <= 6;
        else if (tx_busy_cnt != 0) tx_busy_cnt <= tx_busy_cnt - 1;
    end
    assign bus.TX_STATUS = (tx_busy_cnt != 0);

    // Memory: read data valid the cycle after mem_rd, garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        else bus.mem_rdata <= 32'hBAD0_BAD0;
        if (bus.mem_wr && !reset) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else if (preload_en) mem[preload_idx] <= preload_data;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.TX_EN) begin
                tx_count++;
                check_eq("tx_idle_at_en", bus.TX_STATUS, 0);
                check_eq("tx_pending", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check_eq("tx_byte", bus.TX_DATA, exp_tx.pop_front());
                last_tx = bus.TX_DATA;
            end else if (bus.TX_STATUS) begin
                check_eq("tx_stable", bus.TX_DATA, last_tx);
            end
            if (bus.mem_wr) begin
                logic [63:0] e;
                wr_cycles++;
                check_eq("wr_pending", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check_eq("wr_addr", bus.mem_addr, e[63:32]);
                    check_eq("wr_data", bus.mem_wdata, e[31:0]);
                end
            end
            if (bus.mem_rd) rd_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_STATUS = 1'b1;
        bus.RX_DATA   = b;
        tick();
        bus.RX_STATUS = 1'b0;
    endtask

    task automatic send_bytes(input pkt_t b, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i]);
            if (i != n - 1) repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while ((busy || exp_tx.size() != 0) && i < 500) begin
            tick();
            i++;
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_hold"}, hold, 0);
        check_eq({tag, "_tx_left"}, exp_tx.size(), 0);
        check_eq({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    task automatic clear_counts();
        wr_cycles = 0;
        rd_cycles = 0;
    endtask

    task automatic read_0x20(input string tag);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h78);
        clear_counts();
        send_bytes('{8'h52, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 2);
        check_eq({tag, "_rd_strobe"}, bus.mem_rd, 1);
        tick();
        check_eq({tag, "_rd_cap"}, bus.mem_rd, 1);
        tick();
        check_eq({tag, "_rd_latency"}, bus.TX_EN, 1);
        wait_done(tag);
        check_eq({tag, "_rd_cycles"}, rd_cycles, 2);
        check_eq({tag, "_wr_cycles"}, wr_cycles, 0);
    endtask

    initial begin
        int tx_snap;
        reset         = 1'b1;
        bus.RX_STATUS = 1'b0;
        bus.RX_DATA   = 8'h00;
        repeat (3) tick();

        check_eq("rst_tx_en", bus.TX_EN, 0);
        check_eq("rst_tx_data", bus.TX_DATA, 0);
        check_eq("rst_mem_rd", bus.mem_rd, 0);
        check_eq("rst_mem_wr", bus.mem_wr, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_hold", hold, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Write word
        exp_wr.push_back({32'h0000_0010, 32'hDEAD_BEEF});
        exp_tx.push_back(8'h4B);
        clear_counts();
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 9, 2);
        check_eq("w_latency", bus.mem_wr, 1);
        check_eq("w_hold", hold, 1);
        wait_done("w");
        check_eq("w_wr_cycles", wr_cycles, 1);
        check_eq("w_rd_cycles", rd_cycles, 0);

        // Read word
        preload_idx  = 8'd8;
        preload_data = 32'h1234_5678;
        preload_en   = 1'b1;
        tick();
        preload_en   = 1'b0;
        tick();
        read_0x20("r");

        // Unknown command
        exp_tx.push_back(8'h3F);
        clear_counts();
        tx_snap = tx_count;
        send_byte(8'h41);
        check_eq("unk_hold_rise", hold, 1);
        wait_done("unk");
        check_eq("unk_rd_cycles", rd_cycles, 0);
        check_eq("unk_wr_cycles", wr_cycles, 0);
        check_eq("unk_tx_count", tx_count - tx_snap, 1);

        // Low address bits masked
        exp_wr.push_back({32'h0000_0010, 32'h0000_0001});
        exp_tx.push_back(8'h4B);
        clear_counts();
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h01}, 9, 1);
        wait_done("mask");
        check_eq("mask_wr_cycles", wr_cycles, 1);

        // Reset mid-command, with a byte arriving during reset
        clear_counts();
        tx_snap = tx_count;
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 2);
        reset         = 1'b1;
        bus.RX_STATUS = 1'b1;
        bus.RX_DATA   = 8'h41;
        tick();
        reset         = 1'b0;
        bus.RX_STATUS = 1'b0;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_hold", hold, 0);
        repeat (3) tick();
        check_eq("rst_rx_discard", busy, 0);
        check_eq("rst_no_tx", tx_count - tx_snap, 0);
        read_0x20("after_rst");
        check_eq("rst_no_wr", wr_cycles, 0);

`ifdef CMD_TIMEOUT_EN
        // Inter-byte timeout abandons a partial command
        tx_snap = tx_count;
        send_bytes('{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 2);
        repeat (99) tick();
        check_eq("to_not_yet", busy, 1);
        tick();
        check_eq("to_busy", busy, 0);
        check_eq("to_hold", hold, 0);
        check_eq("to_no_tx", tx_count - tx_snap, 0);
        tick();
        read_0x20("after_to");
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
